vjtag_probe_hub: RTL and testbench



---
 rtl/vjtag_probe_pkg.sv | 23 ++
 rtl/vjtag_probe_sel.sv | 27 ++
 rtl/vjtag_probe_hub.sv | 124 ++++++++++++
 tb/tb_vjtag_probe_hub.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vjtag_probe_pkg.sv
// Shared types and constants for the virtual-JTAG probe hub.
// Imported by the word selector and the hub top.
package vjtag_probe_pkg;

  typedef enum logic [1:0] {
    IR_BYPASS = 2'd0,
    IR_ADDR   = 2'd1,
    IR_READ   = 2'd2,
    IR_WRITE  = 2'd3
  } ir_e;

  localparam int ADDR_W = 7;
  localparam logic [ADDR_W-1:0] ID_INDEX = 7'd127;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/vjtag_probe_sel.sv
// Probe word selector: probe slice, ID word at 127, else zero.
// Purely combinational, one instance per hub.
module vjtag_probe_sel
  import vjtag_probe_pkg::*;
#(
  parameter int          NBITS   = 64,
  parameter int          NPROBES = 32,
  parameter logic [31:0] ID_WORD = 32'h4C41_4232
) (
  input  logic [NPROBES*NBITS-1:0] probe,
  input  logic [ADDR_W-1:0]        idx,
  output logic [NBITS-1:0]         word
);

  localparam logic [NBITS+31:0] ID_EXT =
    {{NBITS{1'b0}}, ID_WORD};

  // Index decode; the ID slot never collides with a probe.
  always_comb begin
    word = '0;
    if (idx == ID_INDEX) word = ID_EXT[NBITS-1:0];
    for (int i = 0; i < NPROBES; i++) begin
      if (idx == ADDR_W'(i)) word = probe[i*NBITS +: NBITS];
    end
  end

endmodule

// File: rtl/vjtag_probe_hub.sv
// Virtual-JTAG debug hub: indexed probe readout,
// auto-increment, and a JTAG-written switch vector.
module vjtag_probe_hub
  import vjtag_probe_pkg::*;
#(
  parameter int          NBITS   = 64,
  parameter int          NPROBES = 32,
  parameter int          NSWI    = 8,
  parameter logic [31:0] ID_WORD = 32'h4C41_4232
) (
  input  logic                     tck,
  input  logic                     reset_n,
  input  logic                     tdi,
  input  logic [1:0]               ir_in,
  input  logic                     cdr,
  input  logic                     sdr,
  input  logic                     udr,
  input  logic [NPROBES*NBITS-1:0] probe,
  output logic                     tdo,
  output logic [NSWI-1:0]          swi_jtag,
  output logic [ADDR_W-1:0]        sel
);

  localparam int SRW = max3(NBITS, 8, NSWI);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NPROBES - 1);

  ir_e               ir;
  logic              bypass;
  logic [SRW-1:0]    sr;
  logic [SRW-1:0]    sr_cap;
  logic [SRW-1:0]    sr_sh;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_inc;
  logic              autoinc;
  logic [NSWI-1:0]   swi;
  logic [NBITS-1:0]  word;
  int                len;

  assign ir = ir_e'(ir_in);

  vjtag_probe_sel #(
    .NBITS   (NBITS),
    .NPROBES (NPROBES),
    .ID_WORD (ID_WORD)
  ) u_sel (
    .probe (probe),
    .idx   (idx),
    .word  (word)
  );

  // Capture value and active DR length per IR.
  always_comb begin
    sr_cap = '0;
    len    = 0;
    unique case (ir)
      IR_BYPASS: sr_cap = sr;
      IR_ADDR: begin
        sr_cap[7:0] = {autoinc, idx};
        len         = 8;
      end
      IR_READ: begin
        sr_cap[NBITS-1:0] = word;
        len               = NBITS;
      end
      IR_WRITE: begin
        sr_cap[NSWI-1:0] = swi;
        len              = NSWI;
      end
    endcase
  end

  // Shift only the low len bits; upper bits hold.
  always_comb begin
    sr_sh = sr;
    for (int j = 0; j < SRW - 1; j++) begin
      if (j < len - 1) sr_sh[j] = sr[j+1];
    end
    for (int j = 0; j < SRW; j++) begin
      if (j == len - 1) sr_sh[j] = tdi;
    end
  end

  // Wrap past the last probe, and from the ID slot.
  always_comb begin
    idx_inc = idx + 7'd1;
    if (idx >= LAST) idx_inc = '0;
  end

  // DR state; capture beats shift beats update.
  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      bypass  <= 1'b0;
      sr      <= '0;
      idx     <= '0;
      autoinc <= 1'b0;
      swi     <= '0;
    end else begin
      bypass <= tdi;
      if (cdr) begin
        sr <= sr_cap;
      end else if (sdr) begin
        sr <= sr_sh;
      end else if (udr) begin
        unique case (ir)
          IR_BYPASS: ;
          IR_ADDR: begin
            idx     <= sr[6:0];
            autoinc <= sr[7];
          end
          IR_READ: begin
            if (autoinc) idx <= idx_inc;
          end
          IR_WRITE: swi <= sr[NSWI-1:0];
        endcase
      end
    end
  end

  assign tdo      = (ir == IR_BYPASS) ? bypass : sr[0];
  assign swi_jtag = swi;
  assign sel      = idx;

endmodule

// File: tb/tb_vjtag_probe_hub.sv
// Directed bench for vjtag_probe_hub: vector table of
// DR scans plus bypass, atomic-capture and reset cases.
module tb_vjtag_probe_hub;

  localparam int NBITS   = 64;
  localparam int NPROBES = 32;
  localparam int NSWI    = 8;

  logic                     tck = 1'b0;
  logic                     reset_n;
  logic                     tdi;
  logic [1:0]               ir_in;
  logic                     cdr, sdr, udr;
  logic [NPROBES*NBITS-1:0] probe;
  logic                     tdo;
  logic [NSWI-1:0]          swi_jtag;
  logic [6:0]               sel;

  int n_tests = 0;
  int n_fail  = 0;

  vjtag_probe_hub #(
    .NBITS   (NBITS),
    .NPROBES (NPROBES),
    .NSWI    (NSWI),
    .ID_WORD (32'h4C41_4232)
  ) dut (
    .tck      (tck),
    .reset_n  (reset_n),
    .tdi      (tdi),
    .ir_in    (ir_in),
    .cdr      (cdr),
    .sdr      (sdr),
    .udr      (udr),
    .probe    (probe),
    .tdo      (tdo),
    .swi_jtag (swi_jtag),
    .sel      (sel)
  );

  always #5 tck = ~tck;

  typedef struct {
    logic [1:0]  ir;
    int          len;
    logic [63:0] din;
    logic [63:0] dout;
    logic [6:0]  sel;
    logic [7:0]  swi_pre;
    logic [7:0]  swi;
  } vec_t;

  vec_t v[13];

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  task automatic scan(input  logic [1:0]  code,
                      input  int          len,
                      input  logic [63:0] din,
                      input  bit          clobber,
                      output logic [63:0] dout,
                      output logic [7:0]  swi_pre);
    ir_in = code;
    cdr   = 1'b1;
    step();
    cdr = 1'b0;
    if (clobber) probe[5*NBITS +: NBITS] = '0;
    dout = '0;
    for (int k = 0; k < len; k++) begin
      dout[k] = tdo;
      tdi     = din[k];
      sdr     = 1'b1;
      step();
    end
    sdr     = 1'b0;
    tdi     = 1'b0;
    swi_pre = swi_jtag;
    udr     = 1'b1;
    step();
    udr = 1'b0;
  endtask

  localparam logic [63:0] W30 = 64'hC0DE_001E_0000_F01E;
  localparam logic [63:0] W31 = 64'hC0DE_001F_0000_F01F;
  localparam logic [63:0] W0  = 64'hC0DE_0000_0000_F000;
  localparam logic [63:0] IDW = 64'h0000_0000_4C41_4232;

  initial begin
    logic [63:0] d;
    logic [7:0]  sp;
    logic        exp_tdi;

    v[0]  = '{2'd1, 8,  64'h9E, 64'h05, 7'd30,  8'h00, 8'h00};
    v[1]  = '{2'd2, 64, 64'h0,  W30,    7'd31,  8'h00, 8'h00};
    v[2]  = '{2'd2, 64, 64'h0,  W31,    7'd0,   8'h00, 8'h00};
    v[3]  = '{2'd2, 64, 64'h0,  W0,     7'd1,   8'h00, 8'h00};
    v[4]  = '{2'd1, 8,  64'h7F, 64'h81, 7'd127, 8'h00, 8'h00};
    v[5]  = '{2'd2, 64, 64'h0,  IDW,    7'd127, 8'h00, 8'h00};
    v[6]  = '{2'd1, 8,  64'h40, 64'h7F, 7'd64,  8'h00, 8'h00};
    v[7]  = '{2'd2, 64, 64'h0,  64'h0,  7'd64,  8'h00, 8'h00};
    v[8]  = '{2'd3, 8,  64'hA5, 64'h00, 7'd64,  8'h00, 8'hA5};
    v[9]  = '{2'd3, 8,  64'h3C, 64'hA5, 7'd64,  8'hA5, 8'h3C};
    v[10] = '{2'd1, 8,  64'hFF, 64'h40, 7'd127, 8'h3C, 8'h3C};
    v[11] = '{2'd2, 64, 64'h0,  IDW,    7'd0,   8'h3C, 8'h3C};
    v[12] = '{2'd2, 64, 64'h0,  W0,     7'd1,   8'h3C, 8'h3C};

    for (int i = 0; i < NPROBES; i++) begin
      probe[i*NBITS +: NBITS] =
        {32'hC0DE_0000 | 32'(i), 32'h0000_F000 | 32'(i)};
    end
    reset_n = 1'b0;
    tdi     = 1'b0;
    ir_in   = 2'd0;
    cdr     = 1'b0;
    sdr     = 1'b0;
    udr     = 1'b0;

    #12;
    chk("rst_tdo_bypass", 64'(tdo), 64'h0);
    chk("rst_swi", 64'(swi_jtag), 64'h0);
    chk("rst_sel", 64'(sel), 64'h0);
    ir_in = 2'd2;
    #1;
    chk("rst_tdo_read", 64'(tdo), 64'h0);
    ir_in   = 2'd0;
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      exp_tdi = (i % 2 == 0);
      tdi     = exp_tdi;
      step();
      chk($sformatf("bypass_%0d", i),
          64'(tdo), 64'(exp_tdi));
      chk($sformatf("bypass_sel_%0d", i), 64'(sel), 64'h0);
      chk($sformatf("bypass_swi_%0d", i),
          64'(swi_jtag), 64'h0);
    end
    tdi = 1'b0;

    probe[5*NBITS +: NBITS] = 64'h0123_4567_89AB_CDEF;
    scan(2'd1, 8, 64'h05, 1'b0, d, sp);
    chk("addr5_dout", d, 64'h00);
    chk("addr5_sel", 64'(sel), 64'd5);
    scan(2'd2, 64, 64'h0, 1'b1, d, sp);
    chk("atomic_dout", d, 64'h0123_4567_89AB_CDEF);
    chk("atomic_sel", 64'(sel), 64'd5);

    for (int i = 0; i < 13; i++) begin
      scan(v[i].ir, v[i].len, v[i].din, 1'b0, d, sp);
      chk($sformatf("vec%0d_dout", i), d, v[i].dout);
      chk($sformatf("vec%0d_sel", i),
          64'(sel), 64'(v[i].sel));
      chk($sformatf("vec%0d_swi_pre", i),
          64'(sp), 64'(v[i].swi_pre));
      chk($sformatf("vec%0d_swi", i),
          64'(swi_jtag), 64'(v[i].swi));
    end

    ir_in = 2'd2;
    cdr   = 1'b1;
    step();
    cdr = 1'b0;
    for (int k = 0; k < 29; k++) begin
      tdi = 1'b1;
      sdr = 1'b1;
      step();
    end
    tdi = 1'b1;
    sdr = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_sel", 64'(sel), 64'h0);
    chk("midrst_swi", 64'(swi_jtag), 64'h0);
    chk("midrst_tdo", 64'(tdo), 64'h0);
    sdr = 1'b0;
    tdi = 1'b0;
    step();
    reset_n = 1'b1;
    scan(2'd2, 64, 64'h0, 1'b0, d, sp);
    chk("postrst_dout", d, W0);
    chk("postrst_sel", 64'(sel), 64'h0);
    chk("postrst_swi", 64'(swi_jtag), 64'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
